vend_sequencer: RTL and testbench

//  Transaction sequencer for the coin-vending datapath: accepts coins, holds the running

---
 rtl/vend_pkg.sv | 43 ++++
 rtl/change_picker.sv | 24 ++
 rtl/vend_sequencer.sv | 125 ++++++++++++
 tb/tb_vend_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared encodings for the coin-vending sequencer: coin types and values, error codes,
// sequencer states and default sizing.
package vend_pkg;

    localparam int MAX_BALANCE_DEFAULT = 100;
    localparam int BAL_W_DEFAULT       = 7;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_QUARTER = 2'b10,
        COIN_BAD     = 2'b11
    } coin_e;

    localparam logic [4:0] VALUE_NICKEL  = 5'd5;
    localparam logic [4:0] VALUE_DIME    = 5'd10;
    localparam logic [4:0] VALUE_QUARTER = 5'd25;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'b000,
        ERR_FULL  = 3'b001,
        ERR_FUNDS = 3'b010,
        ERR_COIN  = 3'b011,
        ERR_PRICE = 3'b100
    } err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        VEND   = 2'b01,
        CHANGE = 2'b10
    } state_e;

    // An invalid coin is worth nothing; callers reject it before crediting.
    function automatic logic [4:0] coin_value(input coin_e c);
        case (c)
            COIN_NICKEL:  return VALUE_NICKEL;
            COIN_DIME:    return VALUE_DIME;
            COIN_QUARTER: return VALUE_QUARTER;
            default:      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_picker.sv
// Greedy change selection: the largest coin that does not exceed the remaining balance.
module change_picker
    import vend_pkg::*;
#(
    parameter int BAL_W = BAL_W_DEFAULT
) (
    input  logic [BAL_W-1:0] balance,
    output logic [1:0]       coin,
    output logic [BAL_W-1:0] value
);

    always_comb begin
        coin  = COIN_NICKEL;
        value = BAL_W'(VALUE_NICKEL);
        if (balance >= BAL_W'(VALUE_QUARTER)) begin
            coin  = COIN_QUARTER;
            value = BAL_W'(VALUE_QUARTER);
        end else if (balance >= BAL_W'(VALUE_DIME)) begin
            coin  = COIN_DIME;
            value = BAL_W'(VALUE_DIME);
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Coin-vending transaction sequencer: credits coins, approves selections, pulses dispense
// and pays change back one coin at a time over a valid/ack handshake.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int MAX_BALANCE = MAX_BALANCE_DEFAULT,
    parameter int BAL_W       = BAL_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    input  logic             sel_valid,
    input  logic [BAL_W-1:0] price,
    input  logic             cancel,
    input  logic             chg_ack,
    output logic [BAL_W-1:0] balance,
    output logic             busy,
    output logic             dispense,
    output logic             coin_reject,
    output logic             chg_valid,
    output logic [1:0]       chg_coin,
    output logic [2:0]       err
);

    localparam logic [BAL_W-1:0] FIVE    = BAL_W'(5);
    localparam logic [BAL_W:0]   MAX_SUM = (BAL_W+1)'(MAX_BALANCE);

    state_e           state, state_nxt;
    err_e             err_q, err_nxt;
    logic [BAL_W-1:0] bal_nxt;
    logic [BAL_W-1:0] price_q, price_nxt;
    logic             reject_nxt;
    logic [BAL_W:0]   coin_sum;
    logic [BAL_W-1:0] chg_value;

    change_picker #(.BAL_W(BAL_W)) u_picker (
        .balance (balance),
        .coin    (chg_coin),
        .value   (chg_value)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            balance     <= '0;
            err_q       <= ERR_NONE;
            price_q     <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            balance     <= bal_nxt;
            err_q       <= err_nxt;
            price_q     <= price_nxt;
            coin_reject <= reject_nxt;
        end
    end

    // The add is widened by one bit so a coin on a near-full balance cannot wrap past the limit.
    always_comb begin
        state_nxt  = state;
        bal_nxt    = balance;
        err_nxt    = err_q;
        price_nxt  = price_q;
        reject_nxt = 1'b0;
        coin_sum   = {1'b0, balance} + (BAL_W+1)'(coin_value(coin_e'(coin_type)));

        case (state)
            IDLE: begin
                if (cancel) begin
                    reject_nxt = coin_valid;
                    if (balance != '0) begin
                        state_nxt = CHANGE;
                        err_nxt   = ERR_NONE;
                    end
                end else if (sel_valid) begin
                    reject_nxt = coin_valid;
                    if ((price == '0) || ((price % FIVE) != '0)) begin
                        err_nxt = ERR_PRICE;
                    end else if (price > balance) begin
                        err_nxt = ERR_FUNDS;
                    end else begin
                        err_nxt   = ERR_NONE;
                        price_nxt = price;
                        state_nxt = VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_e'(coin_type) == COIN_BAD) begin
                        reject_nxt = 1'b1;
                        err_nxt    = ERR_COIN;
                    end else if (coin_sum > MAX_SUM) begin
                        reject_nxt = 1'b1;
                        err_nxt    = ERR_FULL;
                    end else begin
                        bal_nxt = coin_sum[BAL_W-1:0];
                        err_nxt = ERR_NONE;
                    end
                end
            end
            VEND: begin
                reject_nxt = coin_valid;
                bal_nxt    = balance - price_q;
                state_nxt  = (bal_nxt != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_nxt = coin_valid;
                if (chg_ack) begin
                    bal_nxt = balance - chg_value;
                    if (bal_nxt == '0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign dispense  = (state == VEND);
    assign chg_valid = (state == CHANGE);
    assign err       = err_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus randomized traffic, all
// compared every cycle against a cents-level transaction model.
module tb_vend_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       sel_valid = 1'b0;
    logic [6:0] price = 7'd0;
    logic       cancel = 1'b0;
    logic       chg_ack = 1'b0;
    logic [6:0] balance;
    logic       busy;
    logic       dispense;
    logic       coin_reject;
    logic       chg_valid;
    logic [1:0] chg_coin;
    logic [2:0] err;

    int vectors = 0;
    int miscompares = 0;

    // Model of the machine in customer terms: money held, whether an item is being released,
    // whether change is still owed, and the last complaint shown.
    int mBal = 0;
    int mErr = 0;
    int mPrice = 0;
    bit mVend = 1'b0;
    bit mChange = 1'b0;
    bit mReject = 1'b0;

    vend_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .sel_valid   (sel_valid),
        .price       (price),
        .cancel      (cancel),
        .chg_ack     (chg_ack),
        .balance     (balance),
        .busy        (busy),
        .dispense    (dispense),
        .coin_reject (coin_reject),
        .chg_valid   (chg_valid),
        .chg_coin    (chg_coin),
        .err         (err)
    );

    always #5 clock = ~clock;

    function automatic int coinCents(input int t);
        if (t == 0) return 5;
        if (t == 1) return 10;
        if (t == 2) return 25;
        return 0;
    endfunction

    function automatic int bestCoin(input int cents);
        if (cents >= 25) return 2;
        if (cents >= 10) return 1;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mBal = 0;
        mErr = 0;
        mPrice = 0;
        mVend = 1'b0;
        mChange = 1'b0;
        mReject = 1'b0;
    endtask

    task automatic modelStep();
        int v;
        mReject = 1'b0;
        if (mVend) begin
            mReject = coin_valid;
            mBal = mBal - mPrice;
            mVend = 1'b0;
            mChange = (mBal > 0);
        end else if (mChange) begin
            mReject = coin_valid;
            if (chg_ack) begin
                mBal = mBal - coinCents(bestCoin(mBal));
                mChange = (mBal > 0);
            end
        end else if (cancel) begin
            mReject = coin_valid;
            if (mBal > 0) begin
                mChange = 1'b1;
                mErr = 0;
            end
        end else if (sel_valid) begin
            mReject = coin_valid;
            if (int'(price) == 0 || (int'(price) % 5) != 0) mErr = 4;
            else if (int'(price) > mBal) mErr = 2;
            else begin
                mErr = 0;
                mVend = 1'b1;
                mPrice = int'(price);
            end
        end else if (coin_valid) begin
            v = coinCents(int'(coin_type));
            if (coin_type == 2'b11) begin
                mReject = 1'b1;
                mErr = 3;
            end else if (mBal + v > 100) begin
                mReject = 1'b1;
                mErr = 1;
            end else begin
                mBal = mBal + v;
                mErr = 0;
            end
        end
    endtask

    always @(negedge clock) begin
        checkOutput("balance", int'(balance), mBal);
        checkOutput("err", int'(err), mErr);
        checkOutput("dispense", int'(dispense), int'(mVend));
        checkOutput("busy", int'(busy), int'(mVend || mChange));
        checkOutput("coin_reject", int'(coin_reject), int'(mReject));
        checkOutput("chg_valid", int'(chg_valid), int'(mChange));
        if (mChange) checkOutput("chg_coin", int'(chg_coin), bestCoin(mBal));
    end

    // One clock of stimulus; returns just after the falling edge so outputs are settled.
    task automatic applyStimulus(input logic cv, input logic [1:0] ct, input logic sv,
                                 input logic [6:0] pr, input logic cn, input logic ack);
        coin_valid = cv;
        coin_type  = ct;
        sel_valid  = sv;
        price      = pr;
        cancel     = cn;
        chg_ack    = ack;
        @(posedge clock);
        modelStep();
        @(negedge clock);
        #1;
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        chg_ack    = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset();
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic coin(input logic [1:0] t);
        applyStimulus(1'b1, t, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic drainChange();
        applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b1, 1'b0);
        for (int i = 0; i < 12 && (mChange || mVend); i++)
            applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b1);
        checkOutput("drain_done", int'(chg_valid), 0);
        checkOutput("drain_zero", int'(balance), 0);
    endtask

    initial begin
        modelReset();
        doReset();

        coin(2'b10); checkOutput("s1_bal25", int'(balance), 25);
        coin(2'b10); checkOutput("s1_bal50", int'(balance), 50);
        coin(2'b01); checkOutput("s1_bal60", int'(balance), 60);
        checkOutput("s1_err", int'(err), 0);

        applyStimulus(1'b0, 2'b00, 1'b1, 7'd45, 1'b0, 1'b0);
        checkOutput("s3_dispense", int'(dispense), 1);
        applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("s3_dispense_off", int'(dispense), 0);
        checkOutput("s3_bal15", int'(balance), 15);
        checkOutput("s3_coin_dime", int'(chg_coin), 1);
        applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b1);
        checkOutput("s3_coin_nickel", int'(chg_coin), 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b1);
        checkOutput("s3_bal0", int'(balance), 0);
        checkOutput("s3_idle", int'(busy), 0);

        coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b00);
        checkOutput("s2_bal90", int'(balance), 90);
        coin(2'b10);
        checkOutput("s2_reject", int'(coin_reject), 1);
        checkOutput("s2_err_full", int'(err), 1);
        checkOutput("s2_bal_held", int'(balance), 90);
        coin(2'b00);
        checkOutput("s2_bal95", int'(balance), 95);
        checkOutput("s2_err_clr", int'(err), 0);
        drainChange();

        coin(2'b01); coin(2'b01);
        applyStimulus(1'b0, 2'b00, 1'b1, 7'd35, 1'b0, 1'b0);
        checkOutput("s4_err_funds", int'(err), 2);
        checkOutput("s4_no_disp", int'(dispense), 0);
        applyStimulus(1'b0, 2'b00, 1'b1, 7'd12, 1'b0, 1'b0);
        checkOutput("s4_err_price", int'(err), 4);
        coin(2'b11);
        checkOutput("s4_err_coin", int'(err), 3);
        drainChange();

        coin(2'b10); coin(2'b01); coin(2'b00);
        applyStimulus(1'b1, 2'b00, 1'b1, 7'd5, 1'b1, 1'b0);
        checkOutput("s5_reject", int'(coin_reject), 1);
        checkOutput("s5_chg_valid", int'(chg_valid), 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0);
            checkOutput("s5_hold_q", int'(chg_coin), 2);
        end
        coin(2'b10);
        checkOutput("s5_busy_reject", int'(coin_reject), 1);
        checkOutput("s5_bal40", int'(balance), 40);
        applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b1);
        checkOutput("s5_bal15", int'(balance), 15);
        applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b1);
        checkOutput("s5_bal5", int'(balance), 5);
        applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b0, 1'b1);
        checkOutput("s5_done", int'(chg_valid), 0);

        coin(2'b10); coin(2'b01);
        applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 1'b1, 1'b0);
        checkOutput("s6_in_change", int'(chg_valid), 1);
        doReset();
        checkOutput("s6_bal0", int'(balance), 0);
        checkOutput("s6_chg_off", int'(chg_valid), 0);
        checkOutput("s6_idle", int'(busy), 0);

        for (int n = 0; n < 1500; n++) begin
            logic       cv, sv, cn, ack;
            logic [1:0] ct;
            logic [6:0] pr;
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                cv  = ($urandom_range(0, 9) < 4);
                ct  = 2'($urandom_range(0, 3));
                sv  = ($urandom_range(0, 19) < 3);
                cn  = ($urandom_range(0, 19) == 0);
                ack = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0) pr = 7'($urandom_range(0, 127));
                else pr = 7'($urandom_range(0, 20) * 5);
                applyStimulus(cv, ct, sv, pr, cn, ack);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
